dither_error_diffuser: RTL and testbench



---
 rtl/dither_error_diffuser.sv | 163 ++++++++++++++++
 tb/tb_dither_error_diffuser.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dither_error_diffuser.sv
// dither_error_diffuser
// Streaming Floyd-Steinberg error-diffusion datapath. Takes 8-bit grayscale
// pixels in raster order and returns one dithered bit per pixel, one cycle
// after acceptance, at a sustained rate of one pixel per cycle.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid      input pixel valid
//   in_ready      input accepted when in_valid && in_ready
//   in_pix        8-bit unsigned grayscale pixel
//   in_sof        start of frame, forces the accepted pixel to (0,0)
//   out_valid     output valid, held until out_ready
//   out_ready     downstream ready
//   out_bit       dithered pixel, 1 = white
//   out_pix       0x00 / 0xFF mirror of out_bit
//   out_last      final pixel of the frame
//
// Error bookkeeping: errBuf[x] holds the complete weighted error
// (1e + 5e + 3e terms) that the previous row diffused into column x. The row
// being processed builds its own next-row entries in two partial-sum registers
// and writes entry x-1 once pixel x has supplied its 3e term. This write lands
// behind the read pointer, so errBuf[x] is always read before it is rewritten.
module dither_error_diffuser #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int THRESH = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_pix,
    input  logic       in_sof,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic [7:0] out_pix,
    output logic       out_last
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
    localparam logic [7:0]    THRESH_B = 8'(THRESH);

    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic signed [8:0]   eLeft_q, eLeft_d;
    logic signed [11:0]  accPrev_q, accPrev_d;
    logic signed [11:0]  accCur_q, accCur_d;
    logic                outValid_q, outBit_q, outLast_q;

    logic signed [11:0]  errBuf [IMG_W];

    logic                accept;
    logic [XW-1:0]       xEff;
    logic [YW-1:0]       yEff;
    logic                atRowEnd, atLastRow;
    logic signed [11:0]  bRead;
    logic signed [8:0]   eLeftUse;
    logic signed [12:0]  acc, accSh;
    logic signed [10:0]  cSum;
    logic [7:0]          cClamp;
    logic                bitNew;
    logic signed [8:0]   eNew;
    logic signed [11:0]  e12;
    logic signed [11:0]  wrPrev;
    logic                wrEn;

    assign in_ready  = !outValid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = outValid_q;
    assign out_bit   = outBit_q;
    assign out_pix   = {8{outBit_q}};
    assign out_last  = outLast_q;

    // Per-pixel arithmetic. A start-of-frame pixel is processed as (0,0), which
    // also zeroes both diffused error sources because x=0 and y=0.
    always_comb begin
        xEff      = in_sof ? '0 : x_q;
        yEff      = in_sof ? '0 : y_q;
        atRowEnd  = (xEff == X_LAST);
        atLastRow = (yEff == Y_LAST);

        bRead     = (yEff == '0) ? 12'sd0 : errBuf[xEff];
        eLeftUse  = (xEff == '0) ? 9'sd0 : eLeft_q;

        acc   = 13'sd7 * $signed({{4{eLeftUse[8]}}, eLeftUse})
              + $signed({bRead[11], bRead});
        accSh = acc >>> 4;
        cSum  = $signed({3'b000, in_pix}) + 11'(accSh);

        if (cSum < 11'sd0) begin
            cClamp = 8'd0;
        end else if (cSum > 11'sd255) begin
            cClamp = 8'd255;
        end else begin
            cClamp = cSum[7:0];
        end

        bitNew = (cClamp >= THRESH_B);
        eNew   = $signed({1'b0, cClamp}) - (bitNew ? 9'sd255 : 9'sd0);
        e12    = $signed({{3{eNew[8]}}, eNew});

        wrPrev    = accPrev_q + 12'sd3 * e12;
        accPrev_d = ((xEff == '0) ? 12'sd0 : accCur_q) + 12'sd5 * e12;
        accCur_d  = e12;
        eLeft_d   = atRowEnd ? 9'sd0 : eNew;

        if (atRowEnd) begin
            x_d = '0;
            y_d = atLastRow ? '0 : yEff + 1'b1;
        end else begin
            x_d = xEff + 1'b1;
            y_d = yEff;
        end

        // The last row has nobody below it, so its contributions are dropped.
        wrEn = accept && !atLastRow;
    end

    // Line buffer write-back. Entry x-1 is finished by this pixel's 3e term.
    // At the row end the entry for this column is finished too, because there
    // is no right neighbour to supply a 3e term.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            if (xEff != '0) begin
                errBuf[xEff - 1'b1] <= wrPrev;
            end
            if (atRowEnd) begin
                errBuf[xEff] <= accPrev_d;
            end
        end
    end

    // Position, left error, partial sums and the registered output stage.
    // Nothing advances while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q        <= '0;
            y_q        <= '0;
            eLeft_q    <= 9'sd0;
            accPrev_q  <= 12'sd0;
            accCur_q   <= 12'sd0;
            outValid_q <= 1'b0;
            outBit_q   <= 1'b0;
            outLast_q  <= 1'b0;
        end else if (accept) begin
            x_q        <= x_d;
            y_q        <= y_d;
            eLeft_q    <= eLeft_d;
            accPrev_q  <= accPrev_d;
            accCur_q   <= accCur_d;
            outValid_q <= 1'b1;
            outBit_q   <= bitNew;
            outLast_q  <= atRowEnd && atLastRow;
        end else if (out_ready) begin
            outValid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dither_error_diffuser.sv
// tb_dither_error_diffuser
// Self-checking bench for dither_error_diffuser on a 16x4 frame. The reference
// model keeps a full 2-D table of quantization errors and sums the neighbour
// terms directly, independent of how the design stores them.
module tb_dither_error_diffuser;

    localparam int W  = 16;
    localparam int H  = 4;
    localparam int TH = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pix;
    logic       in_sof;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic [7:0] out_pix;
    logic       out_last;

    int checks = 0;
    int errors = 0;

    int expBit[$];
    int expLast[$];
    int obsBits[$];
    int lastSeen;
    int errTab[H][W];
    int mx, my;
    bit bpMode;
    bit prevStall;
    logic prevBit, prevLast;

    dither_error_diffuser #(.IMG_W(W), .IMG_H(H), .THRESH(TH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pix    (in_pix),
        .in_sof    (in_sof),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_pix   (out_pix),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: Floyd-Steinberg on a 2-D error table.
    function automatic void modelPixel(input int p, input bit sof);
        int acc, c, b;
        if (sof) begin
            mx = 0;
            my = 0;
        end
        acc = 0;
        if (mx > 0) acc += 7 * errTab[my][mx-1];
        if (my > 0) begin
            acc += 5 * errTab[my-1][mx];
            if (mx > 0)     acc += errTab[my-1][mx-1];
            if (mx < W - 1) acc += 3 * errTab[my-1][mx+1];
        end
        c = p + (acc >>> 4);
        if (c < 0)   c = 0;
        if (c > 255) c = 255;
        b = (c >= TH) ? 1 : 0;
        errTab[my][mx] = c - (b ? 255 : 0);
        expBit.push_back(b);
        expLast.push_back((mx == W - 1 && my == H - 1) ? 1 : 0);
        if (mx == W - 1) begin
            mx = 0;
            my = (my == H - 1) ? 0 : my + 1;
        end else begin
            mx++;
        end
    endfunction

    // Output scoreboard and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_bit", out_bit, prevBit);
                checkOutput("stall_last", out_last, prevLast);
            end
            prevStall = out_valid && !out_ready;
            prevBit   = out_bit;
            prevLast  = out_last;
            if (out_valid && out_ready) begin
                checkOutput("no_extra_output", 1, expBit.size() > 0);
                if (expBit.size() > 0) begin
                    checkOutput("out_bit", out_bit, expBit[0]);
                    checkOutput("out_pix", out_pix, expBit[0] ? 8'hFF : 8'h00);
                    checkOutput("out_last", out_last, expLast[0]);
                    void'(expBit.pop_front());
                    void'(expLast.pop_front());
                end
                obsBits.push_back(int'(out_bit));
                if (out_last) lastSeen++;
            end
            if (in_valid && in_ready) modelPixel(int'(in_pix), in_sof);
        end
    end

    task automatic applyStimulus(input int p, input bit sof);
        bit took;
        bit done;
        logic [31:0] pv;
        pv = p;
        done = 1'b0;
        in_valid = 1'b1;
        in_pix   = pv[7:0];
        in_sof   = sof;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            out_ready = bpMode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (took) done = 1'b1;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        checkOutput("accept_timeout", done, 1);
    endtask

    task automatic drainOutputs();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && expBit.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        checkOutput("drain_empty", expBit.size(), 0);
        checkOutput("idle_after_drain", out_valid, 0);
    endtask

    task automatic sendFrame(input bit randomPix, input int v, input bit withSof);
        for (int i = 0; i < W * H; i++) begin
            applyStimulus(randomPix ? int'($urandom_range(0, 255)) : v, withSof && (i == 0));
        end
    endtask

    task automatic clearObs();
        obsBits.delete();
        lastSeen = 0;
    endtask

    initial begin
        int ones;
        rst = 1'b1; in_valid = 1'b0; in_pix = 8'd0; in_sof = 1'b0;
        out_ready = 1'b1; bpMode = 1'b0; mx = 0; my = 0; lastSeen = 0;
        prevStall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_bit", out_bit, 0);
        checkOutput("rst_pix", out_pix, 0);
        checkOutput("rst_last", out_last, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 1);

        // Flat 64: first row stays dark.
        $display("[TB] flat 64 frame");
        clearObs();
        sendFrame(1'b0, 64, 1'b1);
        drainOutputs();
        ones = 0;
        for (int i = 0; i < W; i++) ones += obsBits[i];
        checkOutput("flat64_row0_ones", ones, 0);
        checkOutput("flat64_last_count", lastSeen, 1);

        // Rounding at threshold.
        $display("[TB] rounding at threshold");
        clearObs();
        applyStimulus(128, 1'b1);
        applyStimulus(128, 1'b0);
        drainOutputs();
        checkOutput("round_bit0", obsBits[0], 1);
        checkOutput("round_bit1", obsBits[1], 0);

        // Clamp above 255.
        $display("[TB] clamp");
        clearObs();
        applyStimulus(120, 1'b1);
        applyStimulus(250, 1'b0);
        drainOutputs();
        checkOutput("clamp_bit0", obsBits[0], 0);
        checkOutput("clamp_bit1", obsBits[1], 1);

        // Saturated frames.
        $display("[TB] saturated frames");
        clearObs();
        sendFrame(1'b0, 255, 1'b1);
        drainOutputs();
        ones = 0;
        foreach (obsBits[i]) ones += obsBits[i];
        checkOutput("white_ones", ones, W * H);
        checkOutput("white_last_count", lastSeen, 1);
        clearObs();
        sendFrame(1'b0, 0, 1'b1);
        drainOutputs();
        ones = 0;
        foreach (obsBits[i]) ones += obsBits[i];
        checkOutput("black_ones", ones, 0);
        checkOutput("black_last_count", lastSeen, 1);

        // Backpressure with random pixels.
        $display("[TB] backpressure");
        bpMode = 1'b1;
        for (int f = 0; f < 2; f++) begin
            clearObs();
            sendFrame(1'b1, 0, 1'b1);
            drainOutputs();
            checkOutput("bp_output_count", obsBits.size(), W * H);
            checkOutput("bp_last_count", lastSeen, 1);
        end
        bpMode = 1'b0;
        out_ready = 1'b1;

        // Reset at pixel (2,1), then a fresh frame without in_sof.
        $display("[TB] reset mid-frame");
        clearObs();
        for (int i = 0; i <= W + 2; i++) applyStimulus(int'($urandom_range(0, 255)), i == 0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_last", out_last, 0);
        expBit.delete();
        expLast.delete();
        mx = 0;
        my = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearObs();
        sendFrame(1'b1, 0, 1'b0);
        drainOutputs();
        checkOutput("postrst_count", obsBits.size(), W * H);
        checkOutput("postrst_last_count", lastSeen, 1);

        // in_sof mid-row: positive accumulated error would push 127 over 128.
        $display("[TB] sof resync mid-row");
        clearObs();
        for (int i = 0; i < 5; i++) applyStimulus(60, i == 0);
        applyStimulus(127, 1'b1);
        for (int i = 1; i < W * H; i++) applyStimulus(int'($urandom_range(0, 255)), 1'b0);
        drainOutputs();
        checkOutput("sof_resync_bit", obsBits[5], 0);
        checkOutput("sof_last_count", lastSeen, 1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
